// File: rtl/ro_freq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ro_freq_pkg
//  Description : Shared types and constants for the multi-channel
//                ring-oscillator frequency meter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ro_freq_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } state_e;

    // Default build parameters
    localparam int c_N_CH_DEF   = 4;
    localparam int c_CNT_W_DEF  = 32;
    localparam int c_GATE_W_DEF = 24;

    // 100 ms gate at the nominal 1 MHz system clock
    localparam int c_GATE_100MS = 100000;

endpackage : ro_freq_pkg
`default_nettype wire

// File: rtl/ro_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ro_edge_sync
//  Description : Two-flop synchroniser followed by a rising-edge detector for
//                one asynchronous ring-oscillator input. The edge output is
//                high for at most one CLK per input rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_sync (
    input  logic CLK,
    input  logic read_data,
    input  logic i_ro,
    output logic o_edge
);

    logic [1:0] r_sync;
    logic       r_prev;

    // Resynchronise the input and remember the previous synchronised level
    always_ff @(posedge CLK or negedge read_data) begin
        if (!read_data) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_ro};
            r_prev <= r_sync[1];
        end
    end

    assign o_edge = r_sync[1] & ~r_prev;

endmodule : ro_edge_sync
`default_nettype wire

// File: rtl/ro_freq_meter_multi.sv
`default_nettype none
// ============================================================================
//  Module      : ro_freq_meter_multi
//  Description : Counts rising edges on N_CH asynchronous ring-oscillator
//                inputs over a programmable gate of G CLK cycles. Results are
//                snapshotted at the end of each gate and read back through a
//                registered channel multiplexer. Supports one-shot and
//                continuous operation, abort, and saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_freq_meter_multi
    import ro_freq_pkg::*;
#(
    parameter int N_CH   = c_N_CH_DEF,
    parameter int CNT_W  = c_CNT_W_DEF,
    parameter int GATE_W = c_GATE_W_DEF,
    localparam int c_SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               CLK,
    input  logic               read_data,
    input  logic [N_CH-1:0]    ro_in,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic               start,
    input  logic               continuous,
    input  logic               abort,
    input  logic [c_SEL_W-1:0] rd_sel,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   rd_count,
    output logic               rd_ovf,
    output logic               ovf_any
);

    localparam logic [1:0]       c_ST_IDLE  = IDLE;
    localparam logic [1:0]       c_ST_ARM   = ARM;
    localparam logic [1:0]       c_ST_GATE  = GATE;
    localparam logic [1:0]       c_ST_DONE  = DONE;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [c_SEL_W:0] c_N_CH_EXT = (c_SEL_W + 1)'(N_CH);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [GATE_W-1:0] r_gate_len;
    logic [GATE_W-1:0] r_gate_cnt;
    logic              w_gate_last;
    logic              w_in_arm;
    logic              w_in_gate;
    logic              w_commit;
    logic              w_sel_ok;

    logic [N_CH-1:0]   w_edge;
    logic [CNT_W-1:0]  w_cnt [N_CH];
    logic [N_CH-1:0]   w_ovf;

    logic [CNT_W-1:0]  r_snap_cnt [N_CH];
    logic [N_CH-1:0]   r_snap_ovf;
    logic [CNT_W-1:0]  r_rd_count;
    logic              r_rd_ovf;

    assign w_in_arm    = (r_state == c_ST_ARM);
    assign w_in_gate   = (r_state == c_ST_GATE);
    assign w_gate_last = (r_gate_cnt == (r_gate_len - GATE_W'(1)));
    // An abort landing on the DONE cycle suppresses the result update
    assign w_commit    = (r_state == c_ST_DONE) && !abort;
    assign w_sel_ok    = ({1'b0, rd_sel} < c_N_CH_EXT);

    // Next-state logic; abort overrides every other request
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (start) w_state_nxt = c_ST_ARM;
                c_ST_ARM:  w_state_nxt = c_ST_GATE;
                c_ST_GATE: if (w_gate_last) w_state_nxt = c_ST_DONE;
                c_ST_DONE: w_state_nxt = continuous ? c_ST_ARM : c_ST_IDLE;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge read_data) begin
        if (!read_data) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the gate length in ARM (zero promoted to one) and time the gate
    always_ff @(posedge CLK or negedge read_data) begin
        if (!read_data) begin
            r_gate_len <= '0;
            r_gate_cnt <= '0;
        end else if (w_in_arm) begin
            r_gate_len <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            r_gate_cnt <= '0;
        end else if (w_in_gate) begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_ovf;

        ro_edge_sync u_edge_sync (
            .CLK       (CLK),
            .read_data (read_data),
            .i_ro      (ro_in[i]),
            .o_edge    (w_edge[i])
        );

        // Live edge counter: cleared in ARM, counts only inside the gate,
        // sticks at full scale and flags any edge that would have wrapped
        always_ff @(posedge CLK or negedge read_data) begin
            if (!read_data) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_in_arm) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_in_gate && w_edge[i]) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_cnt[i] = r_cnt;
        assign w_ovf[i] = r_ovf;
    end

    // Capture all live results together at the end of a measurement
    always_ff @(posedge CLK or negedge read_data) begin
        if (!read_data) begin
            for (int k = 0; k < N_CH; k++) begin
                r_snap_cnt[k] <= '0;
            end
            r_snap_ovf <= '0;
        end else if (w_commit) begin
            for (int k = 0; k < N_CH; k++) begin
                r_snap_cnt[k] <= w_cnt[k];
            end
            r_snap_ovf <= w_ovf;
        end
    end

    // Registered readout mux; out-of-range selects read as zero
    always_ff @(posedge CLK or negedge read_data) begin
        if (!read_data) begin
            r_rd_count <= '0;
            r_rd_ovf   <= 1'b0;
        end else if (w_sel_ok) begin
            r_rd_count <= r_snap_cnt[rd_sel];
            r_rd_ovf   <= r_snap_ovf[rd_sel];
        end else begin
            r_rd_count <= '0;
            r_rd_ovf   <= 1'b0;
        end
    end

    assign busy     = (r_state != c_ST_IDLE);
    assign done     = w_commit;
    assign rd_count = r_rd_count;
    assign rd_ovf   = r_rd_ovf;
    assign ovf_any  = |r_snap_ovf;

endmodule : ro_freq_meter_multi
`default_nettype wire

// File: tb/tb_ro_freq_meter_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_freq_meter_multi
//  Description : Directed self-checking bench for ro_freq_meter_multi.
//                Instance A uses the default build; instance B (3 channels,
//                4-bit counters) exposes saturation and out-of-range select.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_freq_meter_multi;

    logic        CLK = 1'b0;
    logic        read_data;
    logic [23:0] gate_len;
    logic        start;
    logic        continuous;
    logic        abort;
    logic [1:0]  rd_sel_a;
    logic [1:0]  rd_sel_b;
    logic [3:0]  ro;

    logic        busy_a, done_a, rd_ovf_a, ovf_any_a;
    logic [31:0] rd_count_a;
    logic        busy_b, done_b, rd_ovf_b, ovf_any_b;
    logic [3:0]  rd_count_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n        = 0;
    int seen     = 0;

    always #5 CLK = ~CLK;

    // Free-running cycle count; oscillators change on the falling edge
    always @(negedge CLK) cyc <= cyc + 1;

    assign ro[0] = (cyc % 10) < 5;  // period 10
    assign ro[1] = (cyc % 4)  < 2;  // period 4
    assign ro[2] = (cyc % 2)  < 1;  // period 2
    assign ro[3] = (cyc % 5)  < 2;  // period 5

    ro_freq_meter_multi u_dut_a (
        .CLK        (CLK),
        .read_data  (read_data),
        .ro_in      (ro),
        .gate_len   (gate_len),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .rd_sel     (rd_sel_a),
        .busy       (busy_a),
        .done       (done_a),
        .rd_count   (rd_count_a),
        .rd_ovf     (rd_ovf_a),
        .ovf_any    (ovf_any_a)
    );

    ro_freq_meter_multi #(.N_CH(3), .CNT_W(4), .GATE_W(24)) u_dut_b (
        .CLK        (CLK),
        .read_data  (read_data),
        .ro_in      (ro[2:0]),
        .gate_len   (gate_len),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .rd_sel     (rd_sel_b),
        .busy       (busy_b),
        .done       (done_b),
        .rd_count   (rd_count_b),
        .rd_ovf     (rd_ovf_b),
        .ovf_any    (ovf_any_b)
    );

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; n then counts cycles since start was high
    task automatic launch(input logic [23:0] g);
        gate_len = g;
        start    = 1'b1;
        step();
        start    = 1'b0;
        n        = 1;
    endtask

    task automatic wait_done(input int limit);
        while (!done_a && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic read_a(input logic [1:0] sel, input string tag, input logic [31:0] exp);
        rd_sel_a = sel;
        step();
        chk(tag, rd_count_a, exp);
    endtask

    initial begin
        read_data  = 1'b0;
        gate_len   = '0;
        start      = 1'b0;
        continuous = 1'b0;
        abort      = 1'b0;
        rd_sel_a   = 2'd0;
        rd_sel_b   = 2'd0;
        step();
        step();

        // Reset state
        chk("rst_busy",     32'(busy_a),    0);
        chk("rst_done",     32'(done_a),    0);
        chk("rst_rd_count", rd_count_a,     0);
        chk("rst_rd_ovf",   32'(rd_ovf_a),  0);
        chk("rst_ovf_any",  32'(ovf_any_a), 0);
        chk("rst_ovf_any_b",32'(ovf_any_b), 0);
        read_data = 1'b1;
        step();
        step();

        // Basic measurement, G = 100
        launch(24'd100);
        chk("basic_busy", 32'(busy_a), 1);
        wait_done(300);
        chk("basic_latency", n, 102);
        step();
        chk("basic_done_pulse", 32'(done_a), 0);
        chk("basic_idle",       32'(busy_a), 0);
        read_a(2'd0, "basic_ch0", 10);
        read_a(2'd1, "basic_ch1", 25);
        read_a(2'd2, "basic_ch2", 50);
        read_a(2'd3, "basic_ch3", 20);
        chk("basic_ch3_ovf", 32'(rd_ovf_a),  0);
        chk("basic_ovf_any", 32'(ovf_any_a), 0);
        rd_sel_b = 2'd2;
        step();
        chk("sat_count", 32'(rd_count_b), 15);
        chk("sat_ovf",   32'(rd_ovf_b),   1);
        chk("sat_any",   32'(ovf_any_b),  1);
        rd_sel_b = 2'd3;
        step();
        chk("oor_count", 32'(rd_count_b), 0);
        chk("oor_ovf",   32'(rd_ovf_b),   0);

        // Abort at gate cycle 30
        rd_sel_a = 2'd0;
        launch(24'd100);
        while (n < 31) begin
            step();
            n++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", 32'(busy_a), 0);
        seen = 0;
        repeat (120) begin
            step();
            if (done_a) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_keep_ch0", rd_count_a, 10);
        read_a(2'd1, "abort_keep_ch1", 25);

        // Reset in the middle of a gate
        read_a(2'd0, "pre_rst_ch0", 10);
        launch(24'd100);
        repeat (40) step();
        read_data = 1'b0;
        #1;
        chk("mid_rst_busy",     32'(busy_a),    0);
        chk("mid_rst_done",     32'(done_a),    0);
        chk("mid_rst_rd_count", rd_count_a,     0);
        chk("mid_rst_ovf_any_b",32'(ovf_any_b), 0);
        repeat (3) step();
        read_data = 1'b1;
        repeat (5) step();
        chk("post_rst_idle", 32'(busy_a), 0);
        launch(24'd100);
        wait_done(300);
        chk("post_rst_latency", n, 102);
        step();
        read_a(2'd0, "post_rst_ch0", 10);
        read_a(2'd3, "post_rst_ch3", 20);
        chk("post_rst_ovf_any_b", 32'(ovf_any_b), 1);

        // Continuous mode, G = 50
        continuous = 1'b1;
        launch(24'd50);
        wait_done(200);
        chk("cont_first", n, 52);
        step();
        n = 1;
        wait_done(200);
        chk("cont_period", n, 52);
        step();
        n = 1;
        repeat (10) begin
            step();
            n++;
        end
        continuous = 1'b0;
        wait_done(200);
        chk("cont_last", n, 52);
        step();
        chk("cont_stop_idle", 32'(busy_a), 0);
        seen = 0;
        repeat (60) begin
            step();
            if (done_a) seen++;
        end
        chk("cont_no_extra", seen, 0);
        read_a(2'd2, "cont_ch2", 25);
        read_a(2'd3, "cont_ch3", 10);

        // Start while busy is ignored
        launch(24'd20);
        repeat (9) begin
            step();
            n++;
        end
        start = 1'b1;
        step();
        n++;
        start = 1'b0;
        wait_done(100);
        chk("busy_start_latency", n, 22);
        step();
        chk("busy_start_idle", 32'(busy_a), 0);

        // Zero gate length behaves as one cycle
        launch(24'd0);
        wait_done(20);
        chk("gate0_latency", n, 3);
        step();
        chk("gate0_idle", 32'(busy_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ro_freq_meter_multi
`default_nettype wire
